ofdm_frame_rx: RTL and testbench
================================

OFDM_FRAME_RX -- requirements
Module: ofdm_frame_rx

Interface
REQ-001 SHALL have parameter N_FFT, default 64, which is the data samples per OFDM symbol.
REQ-002 SHALL have parameter CP_LEN, default 16, which is the cyclic-prefix samples per symbol.
REQ-003 SHALL have parameter SYM_PER_FRAME, default 8, which is the OFDM symbols per frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 128 (a power of 2, at least N_FFT), which is the output buffer depth.
REQ-005 SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: when low, input samples are ignored; FSM and FIFO hold.
REQ-008 SHALL have port valid_in, input, 1 bit: I_in/Q_in/sop_in qualifier.
REQ-009 SHALL have ports I_in and Q_in, input, signed 16 bits each: time-domain frame samples.
REQ-010 SHALL have port sop_in, input, 1 bit: first sample (first CP sample) of a frame.
REQ-011 SHALL have port ready_in, input, 1 bit: downstream (FFT) can accept an output sample.
REQ-012 SHALL have ports I and Q, output, signed 16 bits each: CP-stripped samples.
REQ-013 SHALL have port valid_out, output, 1 bit: I/Q/sop/eop are valid.
REQ-014 SHALL have port sop, output, 1 bit: first data sample of each symbol.
REQ-015 SHALL have port eop, output, 1 bit: last data sample of each symbol.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag; a data sample was dropped because the FIFO was full.
REQ-017 SHALL have port frame_err, output, 1 bit: one-cycle pulse when sop_in arrives mid-frame.

Function
REQ-018 An input sample SHALL be accepted only on cycles with enable=1 and valid_in=1; there is no input backpressure.
REQ-019 The FSM SHALL have states IDLE, CP, DATA; counters samp_cnt (0..N_FFT-1 or 0..CP_LEN-1) and sym_cnt (0..SYM_PER_FRAME-1).
REQ-020 In IDLE, an accepted sample with sop_in=1 SHALL count as CP sample 0 and move the FSM to CP; samples without sop_in are discarded.
REQ-021 In CP, the FSM SHALL discard CP_LEN samples in total, then move to DATA with samp_cnt=0.
REQ-022 In DATA, each accepted sample SHALL be written to the FIFO with tag sop=(samp_cnt==0) and eop=(samp_cnt==N_FFT-1).
REQ-023 After DATA sample N_FFT-1, the FSM SHALL go to CP (sym_cnt+1), or to IDLE if sym_cnt==SYM_PER_FRAME-1.
REQ-024 An accepted sop_in=1 in CP or DATA SHALL pulse frame_err for 1 cycle, reset sym_cnt=0, and treat that sample as CP sample 0; the partial symbol already in the FIFO is still delivered.
REQ-025 A DATA sample arriving with the FIFO full SHALL be dropped, overflow set to 1, and counters still advance.
REQ-026 The output SHALL follow a valid/ready handshake: a FIFO entry is popped when valid_out=1 and ready_in=1.
REQ-027 The output registers SHALL load the next entry in the same cycle; an entry SHALL appear at the output 1 cycle after being written into an empty FIFO.
REQ-028 valid_out=1 with ready_in=0 SHALL hold I/Q/sop/eop stable.
REQ-029 A simultaneous FIFO push and pop at full SHALL succeed with no overflow; at empty, the pushed word appears on the next cycle.
REQ-030 The FIFO SHALL wrap pointers modulo FIFO_DEPTH; full/empty SHALL be derived from an extra pointer MSB.

Reset
REQ-031 reset=0 SHALL asynchronously force: FSM=IDLE, all counters=0, FIFO empty, I=Q=0, valid_out=sop=eop=0, overflow=0, frame_err=0.
REQ-032 Reset asserted mid-frame SHALL discard all buffered samples; after release the block SHALL wait for the next sop_in.

Structure
REQ-033 Shared package ofdm_pkg SHALL hold N_FFT, CP_LEN, SYM_PER_FRAME, SAMPLE_W=16 and the FSM state enum; the transmitter SHALL use the same constants.
REQ-034 The FIFO SHALL be a sub-module ofdm_sample_fifo (width 2*SAMPLE_W+2 for I, Q, sop, eop; depth FIFO_DEPTH).

Verification
REQ-035 Scenario: one frame of 8x80 samples with I=index, Q=-index, and ready_in=1 -> 512 outputs; each symbol's first output I equals 16+80k; sop/eop fire exactly 8 times each.
REQ-036 Scenario: ready_in toggled 1-cycle-on/1-cycle-off -> no samples lost or duplicated, outputs stable while stalled, overflow=0.
REQ-037 Scenario: ready_in=0 for a full frame -> exactly 128 samples are buffered, overflow=1, and the first 128 data samples are delivered when ready_in=1.
REQ-038 Scenario: sop_in reasserted at DATA sample 30 of symbol 2 -> frame_err pulses once; symbol 2's 30 samples are output (no eop); the new frame is aligned correctly.
REQ-039 Scenario: reset pulled low for 1 cycle mid-symbol -> all outputs 0 within the same cycle; the next frame after sop_in is output correctly.
REQ-040 Scenario: enable=0 for 20 cycles mid-CP while valid_in=1 -> those samples are ignored and alignment resumes on re-enable.

Source files
------------

// File: rtl/ofdm_pkg.sv
// Shared OFDM framing constants and the receiver FSM state encoding,
// common to the transmitter and receiver.
package ofdm_pkg;

  localparam int N_FFT         = 64;
  localparam int CP_LEN        = 16;
  localparam int SYM_PER_FRAME = 8;
  localparam int SAMPLE_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CP   = 2'd1,
    DATA = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ofdm_sample_fifo.sv
// Sample FIFO whose output register always mirrors the oldest entry, so a pop
// and the load of the next entry happen on the same edge.
module ofdm_sample_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 128
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overflow;

  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_empty_after_pop;
  logic [AW:0]      w_wr_next;
  logic [AW:0]      w_rd_next;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign w_full            = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                             (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop             = i_enable && r_valid && i_ready;
  assign w_push_ok         = i_enable && i_push && (!w_full || w_pop);
  assign w_wr_next         = r_wr_ptr + {{AW{1'b0}}, w_push_ok};
  assign w_rd_next         = r_rd_ptr + {{AW{1'b0}}, w_pop};
  assign w_empty_after_pop = (w_rd_next == r_wr_ptr);

  always_ff @(posedge i_clock) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (i_enable) begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      if (!w_empty_after_pop) begin
        r_valid <= 1'b1;
        r_data  <= r_mem[w_rd_next[AW-1:0]];
      end else if (w_push_ok) begin
        // Nothing older left: the word being pushed becomes the head directly.
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else begin
        r_valid <= 1'b0;
      end
      if (i_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign o_data     = r_data;
  assign o_valid    = r_valid && i_enable;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ofdm_frame_rx.sv
// OFDM frame receiver front end: aligns on sop_in, strips the cyclic prefix and
// buffers data samples with per-symbol sop/eop tags toward the FFT.
//
// state | meaning
// IDLE  | waiting for sop_in; untagged samples are discarded
// CP    | discarding cyclic-prefix samples of the current symbol
// DATA  | forwarding data samples of the current symbol to the FIFO
module ofdm_frame_rx
  import ofdm_pkg::*;
#(
  parameter int N_FFT         = ofdm_pkg::N_FFT,
  parameter int CP_LEN        = ofdm_pkg::CP_LEN,
  parameter int SYM_PER_FRAME = ofdm_pkg::SYM_PER_FRAME,
  parameter int FIFO_DEPTH    = 128
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       valid_in,
  input  logic signed [SAMPLE_W-1:0] I_in,
  input  logic signed [SAMPLE_W-1:0] Q_in,
  input  logic                       sop_in,
  input  logic                       ready_in,
  output logic signed [SAMPLE_W-1:0] I,
  output logic signed [SAMPLE_W-1:0] Q,
  output logic                       valid_out,
  output logic                       sop,
  output logic                       eop,
  output logic                       overflow,
  output logic                       frame_err
);

  localparam int CNT_W  = $clog2((N_FFT > CP_LEN) ? N_FFT : CP_LEN);
  localparam int SYM_W  = (SYM_PER_FRAME > 1) ? $clog2(SYM_PER_FRAME) : 1;
  localparam int FIFO_W = 2 * SAMPLE_W + 2;

  rx_state_t        r_state;
  logic [CNT_W-1:0] r_samp_cnt;
  logic [SYM_W-1:0] r_sym_cnt;
  logic             r_frame_err;

  logic              w_accept;
  logic              w_push;
  logic              w_tag_sop;
  logic              w_tag_eop;
  logic [FIFO_W-1:0] w_push_data;
  logic [FIFO_W-1:0] w_fifo_data;

  assign w_accept    = enable && valid_in;
  assign w_push      = w_accept && (r_state == DATA) && !sop_in;
  assign w_tag_sop   = (r_samp_cnt == '0);
  assign w_tag_eop   = (r_samp_cnt == CNT_W'(N_FFT - 1));
  assign w_push_data = {I_in, Q_in, w_tag_sop, w_tag_eop};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_samp_cnt  <= '0;
      r_sym_cnt   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_accept) begin
        if (sop_in) begin
          // A sop_in always restarts the frame; this sample is CP sample 0.
          r_frame_err <= (r_state != IDLE);
          r_sym_cnt   <= '0;
          if (CP_LEN == 1) begin
            r_state    <= DATA;
            r_samp_cnt <= '0;
          end else begin
            r_state    <= CP;
            r_samp_cnt <= CNT_W'(1);
          end
        end else begin
          case (r_state)
            CP: begin
              if (r_samp_cnt == CNT_W'(CP_LEN - 1)) begin
                r_state    <= DATA;
                r_samp_cnt <= '0;
              end else begin
                r_samp_cnt <= r_samp_cnt + CNT_W'(1);
              end
            end
            DATA: begin
              if (r_samp_cnt == CNT_W'(N_FFT - 1)) begin
                r_samp_cnt <= '0;
                if (r_sym_cnt == SYM_W'(SYM_PER_FRAME - 1)) begin
                  r_state   <= IDLE;
                  r_sym_cnt <= '0;
                end else begin
                  r_state   <= CP;
                  r_sym_cnt <= r_sym_cnt + SYM_W'(1);
                end
              end else begin
                r_samp_cnt <= r_samp_cnt + CNT_W'(1);
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  ofdm_sample_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock    (clock),
    .i_reset_n  (reset),
    .i_enable   (enable),
    .i_push     (w_push),
    .i_data     (w_push_data),
    .i_ready    (ready_in),
    .o_data     (w_fifo_data),
    .o_valid    (valid_out),
    .o_overflow (overflow)
  );

  assign {I, Q, sop, eop} = w_fifo_data;
  assign frame_err        = r_frame_err;

endmodule

// File: tb/tb_ofdm_frame_rx.sv
// Bench for ofdm_frame_rx: table of whole-frame ready/valid patterns plus
// hand-written resync, reset, enable and latency sequences.
module tb_ofdm_frame_rx;

  localparam int CPL    = 16;
  localparam int SYMLEN = 80;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic valid_in = 1'b0;
  logic sop_in = 1'b0;
  logic ready_in = 1'b0;
  logic signed [15:0] I_in = '0;
  logic signed [15:0] Q_in = '0;
  logic signed [15:0] I, Q;
  logic valid_out, sop, eop, overflow, frame_err;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic               s;
    logic               e;
  } smp_t;

  typedef struct {
    string name;
    int    rmode;   // 0: ready high, 1: ready toggles, 2: ready low until cycle rhold
    int    rhold;
    int    gap;     // idle input cycles before each sample
    int    exp_cnt;
    bit    exp_ovf;
  } vec_t;

  smp_t cap[$];
  smp_t expq[$];
  vec_t vecs[4];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rmode = 0;
  int   rhold = 0;
  int   n_ferr = 0;
  bit   stall_prev = 1'b0;
  smp_t held;

  ofdm_frame_rx #(
    .N_FFT         (64),
    .CP_LEN        (16),
    .SYM_PER_FRAME (8),
    .FIFO_DEPTH    (128)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .valid_in  (valid_in),
    .I_in      (I_in),
    .Q_in      (Q_in),
    .sop_in    (sop_in),
    .ready_in  (ready_in),
    .I         (I),
    .Q         (Q),
    .valid_out (valid_out),
    .sop       (sop),
    .eop       (eop),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Output monitor: captures handshakes and checks stall stability.
  always @(negedge clock) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_cmp++;
        if (!valid_out || {I, Q, sop, eop} !== held) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%0b I=%0d Q=%0d sop=%0b eop=%0b, expected v=1 I=%0d Q=%0d sop=%0b eop=%0b",
                   valid_out, I, Q, sop, eop, held.i, held.q, held.s, held.e);
        end
      end
      if (valid_out && ready_in) cap.push_back({I, Q, sop, eop});
      if (frame_err) n_ferr++;
      stall_prev = valid_out && !ready_in;
      held       = {I, Q, sop, eop};
    end
  end

  task automatic tick();
    case (rmode)
      0:       ready_in = 1'b1;
      1:       ready_in = cyc[0];
      default: ready_in = (cyc >= rhold);
    endcase
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic start(input int rm, input int rh);
    reset    = 1'b0;
    enable   = 1'b1;
    valid_in = 1'b0;
    sop_in   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    rmode = rm;
    rhold = rh;
    cyc   = 0;
    n_ferr = 0;
    cap.delete();
    expq.delete();
  endtask

  // Expected outputs: data positions of a frame whose samples carry I=base+p.
  task automatic model_frame(input int base, input int nsamp);
    for (int p = 0; p < nsamp; p++) begin
      int   off;
      smp_t e;
      off = p % SYMLEN;
      if (off >= CPL) begin
        e.i = 16'(base + p);
        e.q = 16'(-(base + p));
        e.s = (off == CPL);
        e.e = (off == SYMLEN - 1);
        expq.push_back(e);
      end
    end
  endtask

  task automatic drive_frame(input int base, input int nsamp, input int gap, input bit first_sop);
    for (int p = 0; p < nsamp; p++) begin
      for (int g = 0; g < gap; g++) begin
        valid_in = 1'b0;
        sop_in   = 1'b0;
        tick();
      end
      valid_in = 1'b1;
      I_in     = 16'(base + p);
      Q_in     = 16'(-(base + p));
      sop_in   = first_sop && (p == 0);
      tick();
    end
    valid_in = 1'b0;
    sop_in   = 1'b0;
  endtask

  task automatic drain(input int n);
    int budget;
    budget   = 3000;
    valid_in = 1'b0;
    sop_in   = 1'b0;
    while (cap.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    repeat (20) tick();
  endtask

  task automatic compare_seq(input string nm, input int n);
    int bad, es, ee, as_, ae;
    bad = -1; es = 0; ee = 0; as_ = 0; ae = 0;
    chk({nm, "_count"}, cap.size(), n);
    for (int k = 0; k < n && k < cap.size(); k++)
      if (bad < 0 && cap[k] !== expq[k]) bad = k;
    if (bad >= 0)
      $display("  detail %s idx %0d: got I=%0d Q=%0d s=%0b e=%0b, expected I=%0d Q=%0d s=%0b e=%0b",
               nm, bad, cap[bad].i, cap[bad].q, cap[bad].s, cap[bad].e,
               expq[bad].i, expq[bad].q, expq[bad].s, expq[bad].e);
    chk({nm, "_first_bad_idx"}, bad, -1);
    for (int k = 0; k < n && k < expq.size(); k++) begin
      es += int'(expq[k].s);
      ee += int'(expq[k].e);
    end
    for (int k = 0; k < cap.size(); k++) begin
      as_ += int'(cap[k].s);
      ae  += int'(cap[k].e);
    end
    chk({nm, "_sop_count"}, as_, es);
    chk({nm, "_eop_count"}, ae, ee);
  endtask

  initial begin
    vecs[0] = '{"rdy_always",    0, 0,   0, 512, 1'b0};
    vecs[1] = '{"rdy_toggle",    1, 0,   1, 512, 1'b0};
    vecs[2] = '{"rdy_low_frame", 2, 640, 0, 128, 1'b1};
    vecs[3] = '{"full_push_pop", 2, 176, 0, 512, 1'b0};

    // Reset state
    @(posedge clock);
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_I", I, 0);
    chk("rst_Q", Q, 0);
    chk("rst_sop", sop, 0);
    chk("rst_eop", eop, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);

    // Whole-frame patterns
    for (int v = 0; v < 4; v++) begin
      start(vecs[v].rmode, vecs[v].rhold);
      model_frame(0, 640);
      drive_frame(0, 640, vecs[v].gap, 1'b1);
      drain(vecs[v].exp_cnt);
      compare_seq(vecs[v].name, vecs[v].exp_cnt);
      for (int k = 0; k < vecs[v].exp_cnt / 64; k++)
        chk({vecs[v].name, "_sym_first_I"},
            (cap.size() > 64 * k) ? longint'(cap[64 * k].i) : -99999, 16 + 80 * k);
      chk({vecs[v].name, "_overflow"}, overflow, vecs[v].exp_ovf);
      chk({vecs[v].name, "_frame_err"}, n_ferr, 0);
    end

    // First-write latency into an empty FIFO, held with ready low
    start(2, 100000);
    drive_frame(500, 16, 0, 1'b1);
    chk("lat_empty_during_cp", valid_out, 0);
    valid_in = 1'b1;
    I_in     = 16'sd516;
    Q_in     = -16'sd516;
    tick();
    valid_in = 1'b0;
    chk("lat_valid_next_cycle", valid_out, 1);
    chk("lat_I", I, 516);
    chk("lat_sop", sop, 1);
    chk("lat_eop", eop, 0);
    rhold = cyc;
    tick();
    chk("lat_empty_after_pop", valid_out, 0);

    // sop_in reasserted at data sample 30 of symbol 2
    start(0, 0);
    model_frame(0, 2 * SYMLEN + CPL + 30);
    model_frame(1000, 640);
    drive_frame(0, 2 * SYMLEN + CPL + 30, 0, 1'b1);
    drive_frame(1000, 640, 0, 1'b1);
    drain(30 + 128 + 512);
    compare_seq("resync", 30 + 128 + 512);
    chk("resync_frame_err_pulses", n_ferr, 1);

    // Asynchronous reset mid-symbol, then untagged leftovers, then a new frame
    start(0, 0);
    drive_frame(0, 300, 0, 1'b1);
    chk("pre_reset_valid", valid_out, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid_out", valid_out, 0);
    chk("mid_rst_I", I, 0);
    chk("mid_rst_Q", Q, 0);
    chk("mid_rst_sop_eop", {sop, eop}, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    cap.delete();
    expq.delete();
    n_ferr = 0;
    drive_frame(300, 50, 0, 1'b0);
    model_frame(2000, 640);
    drive_frame(2000, 640, 0, 1'b1);
    drain(512);
    compare_seq("after_reset", 512);
    chk("after_reset_frame_err", n_ferr, 0);

    // enable low for 20 cycles in the CP of symbol 1 with junk sop_in samples
    start(0, 0);
    model_frame(0, 640);
    drive_frame(0, SYMLEN + 5, 0, 1'b1);
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      valid_in = 1'b1;
      I_in     = 16'sd7777;
      Q_in     = -16'sd7777;
      sop_in   = 1'b1;
      tick();
    end
    enable   = 1'b1;
    valid_in = 1'b0;
    sop_in   = 1'b0;
    drive_frame(SYMLEN + 5, 640 - (SYMLEN + 5), 0, 1'b0);
    drain(512);
    compare_seq("enable_gap", 512);
    chk("enable_gap_frame_err", n_ferr, 0);
    chk("enable_gap_overflow", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
